// File: rtl/swg_buffer_writer.sv
// Write-side front end of the sliding window generator cyclic buffer.
// Accepts the input stream, addresses the buffer, tracks occupancy and gates the reader per image.
module swg_buffer_writer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int IMG_ELEMS = 64,
  parameter int PREFILL   = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       write_enable,
  output logic [$clog2(DEPTH)-1:0]   write_addr,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       rd_free,
  output logic                       read_start,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       image_done,
  output logic                       err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(IMG_ELEMS + 1);

  localparam logic [AW-1:0] WP_LAST     = AW'(DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX    = FW'(DEPTH);
  localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);
  localparam logic [CW-1:0] CNT_LAST    = CW'(IMG_ELEMS);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wp;
  logic [CW-1:0] wcnt;

  logic          accept;
  logic          release_slot;
  logic          last_elem;
  logic [FW-1:0] fill_nxt;
  logic [CW-1:0] wcnt_nxt;

  // Reset is folded into ready so nothing is accepted while rst_n is low.
  assign in_ready     = rst_n && (fill_level < FILL_MAX) && (state != DRAIN);
  assign accept       = in_valid && in_ready;
  assign release_slot = rd_free && (fill_level != '0);

  assign write_enable = accept;
  assign write_addr   = wp;
  assign data_out     = in_data;

  always_comb begin
    fill_nxt = fill_level;
    if (accept && !release_slot) begin
      fill_nxt = fill_level + 1'b1;
    end else if (!accept && release_slot) begin
      fill_nxt = fill_level - 1'b1;
    end
  end

  assign wcnt_nxt  = accept ? wcnt + 1'b1 : wcnt;
  assign last_elem = accept && (wcnt_nxt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      wp            <= '0;
      wcnt          <= '0;
      fill_level    <= '0;
      read_start    <= 1'b0;
      image_done    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      image_done <= 1'b0;
      fill_level <= fill_nxt;
      if (rd_free && (fill_level == '0)) begin
        err_underflow <= 1'b1;
      end
      if (accept) begin
        wp   <= (wp == WP_LAST) ? '0 : wp + 1'b1;
        wcnt <= wcnt_nxt;
      end

      case (state)
        FILL: begin
          // A short image may finish before PREFILL is reached; the reader must still run it out.
          if (last_elem) begin
            state      <= DRAIN;
            read_start <= 1'b1;
          end else if (fill_nxt >= PREFILL_LVL) begin
            state      <= RUN;
            read_start <= 1'b1;
          end
        end
        RUN: begin
          read_start <= 1'b1;
          if (last_elem) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fill_nxt == '0) begin
            state      <= FILL;
            read_start <= 1'b0;
            image_done <= 1'b1;
            wp         <= '0;
            wcnt       <= '0;
          end
        end
        default: begin
          state      <= FILL;
          read_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
